// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt stage.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J,
    RD_F,
    LAT_F,
    WR_DEC,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

endpackage

// File: rtl/rc4_char_check.sv
// Flags whether a decrypted byte is a plausible plaintext character (space or a..z).
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid
);

  assign valid = (data == ASCII_SPACE) || ((data >= ASCII_LO) && (data <= ASCII_HI));

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA: swaps S in place, XORs the keystream with encrypted ROM bytes and
// writes the plaintext to the decrypted RAM. All RAM-facing outputs are registered.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN      = 32,
  parameter bit CHECK_ASCII  = 1'b1,
  parameter bit ABORT_ON_BAD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finished,
  output logic       bad_char,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren
);

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] i, j, k, si, sj, f, enc;
  logic [7:0] i_nxt, j_nxt, k_nxt, si_nxt, sj_nxt, f_nxt, enc_nxt;
  logic [7:0] s_address_nxt, s_data_nxt, rom_address_nxt, dec_address_nxt, dec_data_nxt;
  logic       s_wren_nxt, dec_wren_nxt, finished_nxt, bad_char_nxt;
  logic [7:0] plain;
  logic       plain_ok, byte_bad;

  assign plain    = f ^ enc;
  assign byte_bad = CHECK_ASCII && !plain_ok;

  rc4_char_check u_char_check (
    .data  (plain),
    .valid (plain_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      enc         <= '0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
      finished    <= 1'b0;
      bad_char    <= 1'b0;
    end else begin
      state       <= state_nxt;
      i           <= i_nxt;
      j           <= j_nxt;
      k           <= k_nxt;
      si          <= si_nxt;
      sj          <= sj_nxt;
      f           <= f_nxt;
      enc         <= enc_nxt;
      s_address   <= s_address_nxt;
      s_data      <= s_data_nxt;
      s_wren      <= s_wren_nxt;
      rom_address <= rom_address_nxt;
      dec_address <= dec_address_nxt;
      dec_data    <= dec_data_nxt;
      dec_wren    <= dec_wren_nxt;
      finished    <= finished_nxt;
      bad_char    <= bad_char_nxt;
    end
  end

  // Outputs are computed for the state being entered, so they are valid for its whole cycle.
  always_comb begin
    state_nxt       = state;
    i_nxt           = i;
    j_nxt           = j;
    k_nxt           = k;
    si_nxt          = si;
    sj_nxt          = sj;
    f_nxt           = f;
    enc_nxt         = enc;
    s_address_nxt   = '0;
    s_data_nxt      = '0;
    s_wren_nxt      = 1'b0;
    rom_address_nxt = '0;
    dec_address_nxt = '0;
    dec_data_nxt    = '0;
    dec_wren_nxt    = 1'b0;
    finished_nxt    = 1'b0;
    bad_char_nxt    = bad_char;

    case (state)
      IDLE: begin
        if (start) begin
          i_nxt         = 8'd1;
          j_nxt         = '0;
          k_nxt         = '0;
          bad_char_nxt  = 1'b0;
          s_address_nxt = 8'd1;
          state_nxt     = RD_I;
        end
      end
      RD_I:  state_nxt = LAT_I;
      LAT_I: begin
        si_nxt        = s_q;
        j_nxt         = j + s_q;
        s_address_nxt = j + s_q;
        state_nxt     = RD_J;
      end
      RD_J:  state_nxt = LAT_J;
      LAT_J: begin
        sj_nxt        = s_q;
        s_address_nxt = i;
        s_data_nxt    = s_q;
        s_wren_nxt    = 1'b1;
        state_nxt     = WR_I;
      end
      WR_I: begin
        // When i == j this second write lands on the same word and leaves si there.
        s_address_nxt = j;
        s_data_nxt    = si;
        s_wren_nxt    = 1'b1;
        state_nxt     = WR_J;
      end
      WR_J: begin
        s_address_nxt   = si + sj;
        rom_address_nxt = k;
        state_nxt       = RD_F;
      end
      RD_F:  state_nxt = LAT_F;
      LAT_F: begin
        f_nxt           = s_q;
        enc_nxt         = rom_q;
        dec_address_nxt = k;
        dec_data_nxt    = s_q ^ rom_q;
        dec_wren_nxt    = 1'b1;
        // WR_DEC doubles as the S[i+1] read of the next byte, keeping 8 cycles per byte.
        s_address_nxt   = i + 8'd1;
        state_nxt       = WR_DEC;
      end
      WR_DEC: begin
        i_nxt = i + 8'd1;
        if (byte_bad) bad_char_nxt = 1'b1;
        if ((k == LAST_K) || (ABORT_ON_BAD && byte_bad)) begin
          finished_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          k_nxt     = k + 8'd1;
          state_nxt = LAT_I;
        end
      end
      DONE: begin
        if (start) finished_nxt = 1'b1;
        else       state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: four parameterisations share one set of memory models.
module tb_rc4_prga_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start;
  logic [1:0] sel;

  logic       finished    [4];
  logic       bad_char    [4];
  logic [7:0] s_address   [4];
  logic [7:0] s_data      [4];
  logic       s_wren      [4];
  logic [7:0] rom_address [4];
  logic [7:0] dec_address [4];
  logic [7:0] dec_data    [4];
  logic       dec_wren    [4];
  logic [7:0] s_q, rom_q;

  logic [7:0] s_mem   [256];
  logic [7:0] rom_mem [256];
  logic [7:0] dec_mem [256];
  int         dec_cnt, clash_cnt;

  logic       ld_en;
  logic [1:0] ld_tgt;
  logic [7:0] ld_addr, ld_data;

  logic [7:0] ms      [256];
  logic [7:0] ms0     [256];
  logic [7:0] rom_img [256];
  logic [7:0] exp_dec [256];

  int n_checks = 0;
  int n_fail   = 0;
  string pt_long = "the quick brown fox jumps over a";
  string pt_key  = "Plaintext";

  always #5 clk = ~clk;

  // DUT 0: MSG_LEN=2 no check; 1: 9 check; 2: 9 check+abort; 3: 32 check
  for (genvar g = 0; g < 4; g++) begin : g_dut
    rc4_prga_decrypt #(
      .MSG_LEN      (g == 0 ? 2 : (g == 3 ? 32 : 9)),
      .CHECK_ASCII  (g != 0),
      .ABORT_ON_BAD (g == 2)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start[g]),
      .finished    (finished[g]),
      .bad_char    (bad_char[g]),
      .s_address   (s_address[g]),
      .s_data      (s_data[g]),
      .s_wren      (s_wren[g]),
      .s_q         (s_q),
      .rom_address (rom_address[g]),
      .rom_q       (rom_q),
      .dec_address (dec_address[g]),
      .dec_data    (dec_data[g]),
      .dec_wren    (dec_wren[g])
    );
  end

  always @(posedge clk) begin
    s_q   <= s_mem[s_address[sel]];
    rom_q <= rom_mem[rom_address[sel]];
    if (ld_en) begin
      case (ld_tgt)
        2'd0: s_mem[ld_addr] <= ld_data;
        2'd1: rom_mem[ld_addr] <= ld_data;
        default: begin
          dec_mem[ld_addr] <= 8'h00;
          dec_cnt   <= 0;
          clash_cnt <= 0;
        end
      endcase
    end else begin
      if (s_wren[sel]) s_mem[s_address[sel]] <= s_data[sel];
      if (dec_wren[sel]) begin
        dec_mem[dec_address[sel]] <= dec_data[sel];
        dec_cnt <= dec_cnt + 1;
      end
      if (s_wren[sel] && dec_wren[sel]) clash_cnt <= clash_cnt + 1;
    end
  end

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] jj, tmp;
    key = '{8'h4B, 8'h65, 8'h79};
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    jj = 8'h00;
    for (int x = 0; x < 256; x++) begin
      jj = jj + ms[x] + key[x % 3];
      tmp = ms[x];
      ms[x] = ms[jj];
      ms[jj] = tmp;
    end
  endtask

  // Reference RC4 PRGA over ms, producing expected plaintext in exp_dec.
  task automatic model(input int n);
    logic [7:0] mi, mj, a, b;
    mi = 8'h00;
    mj = 8'h00;
    for (int x = 0; x < n; x++) begin
      mi = mi + 8'd1;
      a = ms[mi];
      mj = mj + a;
      b = ms[mj];
      ms[mi] = b;
      ms[mj] = a;
      exp_dec[x] = ms[8'(a + b)] ^ rom_img[x];
    end
  endtask

  task automatic load_mem(input logic [1:0] tgt, input int n);
    for (int x = 0; x < n; x++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_tgt  = tgt;
      ld_addr = 8'(x);
      ld_data = (tgt == 2'd0) ? ms[x] : rom_img[x];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input bit drop_mid, output int lat);
    @(negedge clk);
    start[sel] = 1'b1;
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (drop_mid && lat == 20) start[sel] = 1'b0;
      if (finished[sel]) break;
    end
    n_checks++;
    if (finished[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL run_timeout dut%0d: finished=%b after %0d edges, required 1", sel, finished[sel], lat);
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start[sel] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (finished[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL finished_clear dut%0d: got %b, required 0", sel, finished[sel]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if ({finished[g], bad_char[g], s_address[g], s_data[g], s_wren[g], rom_address[g],
           dec_address[g], dec_data[g], dec_wren[g]} !== 44'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: s_address=%h dec_data=%h finished=%b, required all 0",
                 g, s_address[g], dec_data[g], finished[g]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int lat;
    sel = 2'd0;
    for (int x = 0; x < 256; x++) begin
      ms[x] = 8'(x);
      rom_img[x] = 8'h00;
    end
    load_mem(2'd0, 256);
    load_mem(2'd1, 2);
    load_mem(2'd2, 256);
    run(1'b0, lat);
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL id_latency: got %0d, required 17", lat); end
    n_checks++;
    if (dec_mem[0] !== 8'h02) begin n_fail++; $display("FAIL id_dec0: got %h, required 02", dec_mem[0]); end
    n_checks++;
    if (dec_mem[1] !== 8'h05) begin n_fail++; $display("FAIL id_dec1: got %h, required 05", dec_mem[1]); end
    n_checks++;
    if (s_mem[2] !== 8'h03) begin n_fail++; $display("FAIL id_s2: got %h, required 03", s_mem[2]); end
    n_checks++;
    if (s_mem[3] !== 8'h02) begin n_fail++; $display("FAIL id_s3: got %h, required 02", s_mem[3]); end
    n_checks++;
    if (s_mem[1] !== 8'h01) begin n_fail++; $display("FAIL id_s1_same_addr: got %h, required 01", s_mem[1]); end
    n_checks++;
    if (bad_char[0] !== 1'b0) begin n_fail++; $display("FAIL id_bad_char: got %b, required 0", bad_char[0]); end
    n_checks++;
    if (dec_cnt !== 2) begin n_fail++; $display("FAIL id_dec_writes: got %0d, required 2", dec_cnt); end
    drop_start();
  endtask

  task automatic test_plaintext();
    int lat;
    logic [7:0] ct [9];
    logic [7:0] ch;
    sel = 2'd1;
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int x = 0; x < 9; x++) rom_img[x] = ct[x];
    ksa_key();
    load_mem(2'd0, 256);
    load_mem(2'd1, 9);
    load_mem(2'd2, 256);
    run(1'b1, lat);
    n_checks++;
    if (lat !== 73) begin n_fail++; $display("FAIL pt_latency: got %0d, required 73", lat); end
    for (int x = 0; x < 9; x++) begin
      ch = pt_key[x];
      n_checks++;
      if (dec_mem[x] !== ch) begin
        n_fail++;
        $display("FAIL pt_dec[%0d]: got %h, required %h", x, dec_mem[x], ch);
      end
    end
    n_checks++;
    if (bad_char[1] !== 1'b1) begin n_fail++; $display("FAIL pt_bad_char: got %b, required 1", bad_char[1]); end
    n_checks++;
    if (clash_cnt !== 0) begin n_fail++; $display("FAIL pt_wren_clash: got %0d, required 0", clash_cnt); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat;
    sel = 2'd2;
    ksa_key();
    load_mem(2'd0, 256);
    load_mem(2'd2, 256);
    run(1'b0, lat);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL abort_latency: got %0d, required 9", lat); end
    n_checks++;
    if (dec_cnt !== 1) begin n_fail++; $display("FAIL abort_writes: got %0d, required 1", dec_cnt); end
    n_checks++;
    if (dec_mem[0] !== 8'h50) begin n_fail++; $display("FAIL abort_dec0: got %h, required 50", dec_mem[0]); end
    n_checks++;
    if (bad_char[2] !== 1'b1) begin n_fail++; $display("FAIL abort_bad_char: got %b, required 1", bad_char[2]); end
    drop_start();
  endtask

  task automatic test_latency();
    int lat;
    logic [7:0] ch;
    sel = 2'd3;
    ksa_key();
    ms0 = ms;
    for (int x = 0; x < 256; x++) rom_img[x] = 8'h00;
    model(32);
    ms = ms0;
    for (int x = 0; x < 32; x++) begin
      ch = pt_long[x];
      rom_img[x] = exp_dec[x] ^ ch;
    end
    load_mem(2'd0, 256);
    load_mem(2'd1, 32);
    load_mem(2'd2, 256);
    run(1'b0, lat);
    n_checks++;
    if (lat !== 257) begin n_fail++; $display("FAIL lat_latency: got %0d, required 257", lat); end
    for (int x = 0; x < 32; x += 7) begin
      ch = pt_long[x];
      n_checks++;
      if (dec_mem[x] !== ch) begin
        n_fail++;
        $display("FAIL lat_dec[%0d]: got %h, required %h", x, dec_mem[x], ch);
      end
    end
    n_checks++;
    if (bad_char[3] !== 1'b0) begin n_fail++; $display("FAIL lat_bad_char: got %b, required 0", bad_char[3]); end
    drop_start();
  endtask

  task automatic test_hold_restart();
    int lat, diffs;
    sel = 2'd3;
    ksa_key();
    load_mem(2'd0, 256);
    model(32);
    model(32);
    load_mem(2'd2, 256);
    run(1'b0, lat);
    repeat (20) @(negedge clk);
    n_checks++;
    if (finished[3] !== 1'b1) begin n_fail++; $display("FAIL hold_finished: got %b, required 1", finished[3]); end
    n_checks++;
    if (dec_cnt !== 32) begin n_fail++; $display("FAIL hold_no_restart: dec writes %0d, required 32", dec_cnt); end
    drop_start();
    load_mem(2'd2, 256);
    run(1'b0, lat);
    n_checks++;
    if (lat !== 257) begin n_fail++; $display("FAIL hold_latency2: got %0d, required 257", lat); end
    diffs = 0;
    for (int x = 0; x < 32; x++) if (dec_mem[x] !== exp_dec[x]) diffs++;
    n_checks++;
    if (diffs !== 0) begin
      n_fail++;
      $display("FAIL hold_second_run: %0d bytes differ (dec0 %h, required %h)", diffs, dec_mem[0], exp_dec[0]);
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    int lat, diffs;
    logic [7:0] ch;
    sel = 2'd3;
    ksa_key();
    ms0 = ms;
    load_mem(2'd0, 256);
    model(32);
    load_mem(2'd2, 256);
    @(negedge clk);
    start[3] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_address[3] !== ms0[1]) begin
      n_fail++;
      $display("FAIL mid_rd_j_addr: got %h, required %h", s_address[3], ms0[1]);
    end
    start[3] = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({finished[3], bad_char[3], s_address[3], s_data[3], s_wren[3], rom_address[3],
         dec_address[3], dec_data[3], dec_wren[3]} !== 44'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: s_address=%h finished=%b, required all 0", s_address[3], finished[3]);
    end
    diffs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms0[x]) diffs++;
    n_checks++;
    if (diffs !== 0) begin n_fail++; $display("FAIL mid_s_untouched: %0d words differ, required 0", diffs); end
    @(negedge clk);
    reset = 1'b1;
    run(1'b0, lat);
    n_checks++;
    if (lat !== 257) begin n_fail++; $display("FAIL mid_latency: got %0d, required 257", lat); end
    diffs = 0;
    for (int x = 0; x < 32; x++) begin
      ch = pt_long[x];
      if (dec_mem[x] !== ch) diffs++;
    end
    n_checks++;
    if (diffs !== 0) begin n_fail++; $display("FAIL mid_rerun_dec: %0d bytes differ, required 0", diffs); end
    n_checks++;
    if (clash_cnt !== 0) begin n_fail++; $display("FAIL mid_wren_clash: got %0d, required 0", clash_cnt); end
    drop_start();
  endtask

  initial begin
    start   = 4'b0000;
    sel     = 2'd0;
    ld_en   = 1'b0;
    ld_tgt  = 2'd0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    test_reset();
    test_identity();
    test_plaintext();
    test_abort();
    test_latency();
    test_hold_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
